// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: CPU port 0 is preferred,
// DMA port 1 is protected against starvation, and either port may lock the RAM for RMW.
module ram_arbiter #(
    parameter int unsigned WORD_SIZE    = 20,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_i,
    input  logic                 lock0_i,
    input  logic                 we0_i,
    input  logic [WORD_SIZE-1:0] addr0_i,
    input  logic [WORD_SIZE-1:0] wdata0_i,
    input  logic                 req1_i,
    input  logic                 lock1_i,
    input  logic                 we1_i,
    input  logic [WORD_SIZE-1:0] addr1_i,
    input  logic [WORD_SIZE-1:0] wdata1_i,
    output logic                 gnt0_o,
    output logic                 gnt1_o,
    output logic                 rvalid0_o,
    output logic                 rvalid1_o,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic [WORD_SIZE-1:0] ram_addr_o,
    output logic [WORD_SIZE-1:0] ram_value_o,
    output logic                 ram_write_o,
    input  logic [WORD_SIZE-1:0] ram_value_i
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OwnNone,
        OwnP0,
        OwnP1
    } owner_t;

    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             win0;
    logic             win1;

    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (!reset) begin
            unique case (owner)
                OwnP0: win0 = req0_i;
                OwnP1: win1 = req1_i;
                default: begin
                    if (req0_i && req1_i) begin
                        if (starve_cnt == LIMIT) win1 = 1'b1;
                        else                     win0 = 1'b1;
                    end else begin
                        win0 = req0_i;
                        win1 = req1_i;
                    end
                end
            endcase
        end
    end

    // With no winner the RAM muxes rest on port 0 and no write is issued.
    always_comb begin
        gnt0_o      = win0;
        gnt1_o      = win1;
        ram_addr_o  = win1 ? addr1_i : addr0_i;
        ram_value_o = win1 ? wdata1_i : wdata0_i;
        ram_write_o = win1 ? we1_i : (win0 & we0_i);
        rdata_o     = ram_value_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OwnNone;
            starve_cnt <= '0;
            rvalid0_o  <= 1'b0;
            rvalid1_o  <= 1'b0;
        end else begin
            rvalid0_o <= win0 & ~we0_i;
            rvalid1_o <= win1 & ~we1_i;

            if (win1 || !req1_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // A granted unlocked access or a dropped request ends the owner's lock.
            if (win0 && lock0_i) begin
                owner <= OwnP0;
            end else if (win1 && lock1_i) begin
                owner <= OwnP1;
            end else if ((owner == OwnP0 && (!req0_i || win0)) ||
                         (owner == OwnP1 && (!req1_i || win1))) begin
                owner <= OwnNone;
            end
        end
    end

endmodule
